// File: rtl/eth_mdio_slave.sv
// MDIO (clause 22) management slave with a 32x16 register file, oversampled on clk.
// Define ETH_MDIO_SLAVE_BCAST_EN to also answer PHY address 0.
module eth_mdio_slave #(
   parameter logic [4:0]  G_PHYAD  = 5'd1,
   parameter logic [15:0] G_PHYID1 = 16'h0000,
   parameter logic [15:0] G_PHYID2 = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_in_mdc,
   input  logic        p_in_mdio,
   output logic        p_out_mdio,
   output logic        p_out_mdio_t,
   input  logic        usr_wr,
   input  logic [4:0]  usr_wr_areg,
   input  logic [15:0] usr_wr_data,
   input  logic [4:0]  usr_rd_areg,
   output logic [15:0] usr_rd_data,
   output logic        usr_evt_wr,
   output logic        usr_evt_rd,
   output logic [4:0]  usr_evt_areg,
   output logic [15:0] usr_evt_data
);

   typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

   logic [2:0]  mdc_sync_q, mdc_sync_d, mdio_sync_q, mdio_sync_d;
   logic        rise_q, rise_d, fall_q, fall_d;
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [15:0] sh_q, sh_d;
   logic        read_q, read_d, match_q, match_d;
   logic [4:0]  regad_q, regad_d;
   logic        mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
   logic        evt_wr_q, evt_wr_d, evt_rd_q, evt_rd_d;
   logic [4:0]  evt_areg_q, evt_areg_d;
   logic [15:0] evt_data_q, evt_data_d;
   logic [15:0] regs_q [32];
   logic [15:0] regs_d [32];
   logic        commit, bit_in;
   logic [4:0]  addr_in;
   logic [15:0] commit_data, snap_data;

   function automatic logic phy_match(input logic [4:0] a);
`ifdef ETH_MDIO_SLAVE_BCAST_EN
      return (a == G_PHYAD) || (a == 5'd0);
`else
      return a == G_PHYAD;
`endif
   endfunction

   // Third sync stage is the previous value for edge detection; the mdio chain is
   // kept equally deep so the sampled bit lines up with the registered edge flag.
   always_comb begin
      mdc_sync_d  = {mdc_sync_q[1:0], p_in_mdc};
      mdio_sync_d = {mdio_sync_q[1:0], p_in_mdio};
      rise_d      = mdc_sync_q[1] & ~mdc_sync_q[2];
      fall_d      = ~mdc_sync_q[1] & mdc_sync_q[2];
   end

   assign bit_in      = mdio_sync_q[2];
   assign addr_in     = {sh_q[3:0], bit_in};
   assign commit_data = {sh_q[14:0], bit_in};
   assign snap_data   = (regad_q == 5'd2) ? G_PHYID1 :
                        (regad_q == 5'd3) ? G_PHYID2 : regs_q[regad_q];
   assign usr_rd_data = (usr_rd_areg == 5'd2) ? G_PHYID1 :
                        (usr_rd_areg == 5'd3) ? G_PHYID2 : regs_q[usr_rd_areg];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      read_d     = read_q;
      match_d    = match_q;
      regad_d    = regad_q;
      mdio_o_d   = mdio_o_q;
      mdio_t_d   = mdio_t_q;
      evt_wr_d   = 1'b0;
      evt_rd_d   = 1'b0;
      evt_areg_d = evt_areg_q;
      evt_data_d = evt_data_q;
      commit     = 1'b0;
      case (state_q)
         IDLE: if (rise_q) begin
            if (bit_in) begin
               if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
            end else begin
               if (cnt_q == 6'd32) state_d = ST;
               cnt_d = '0;
            end
         end
         ST: if (rise_q) begin
            cnt_d   = '0;
            state_d = bit_in ? OP : IDLE;
         end
         OP: if (rise_q) begin
            if (cnt_q == 6'd0) begin
               read_d = bit_in;
               cnt_d  = 6'd1;
            end else begin
               cnt_d   = '0;
               state_d = (read_q != bit_in) ? PHYAD : IDLE;
            end
         end
         PHYAD: if (rise_q) begin
            sh_d = {sh_q[14:0], bit_in};
            if (cnt_q == 6'd4) begin
               cnt_d   = '0;
               match_d = phy_match(addr_in);
               state_d = REGAD;
            end else cnt_d = cnt_q + 6'd1;
         end
         REGAD: if (rise_q) begin
            sh_d = {sh_q[14:0], bit_in};
            if (cnt_q == 6'd4) begin
               cnt_d   = '0;
               regad_d = addr_in;
               state_d = TA;
            end else cnt_d = cnt_q + 6'd1;
         end
         // Snapshot on the first TA bit, take the bus on the fall before the second.
         TA: begin
            if (rise_q) begin
               if (cnt_q == 6'd0) begin
                  cnt_d = 6'd1;
                  if (read_q && match_q) sh_d = snap_data;
               end else begin
                  cnt_d   = '0;
                  state_d = DATA;
               end
            end else if (fall_q && cnt_q == 6'd1 && read_q && match_q) begin
               mdio_t_d = 1'b0;
               mdio_o_d = 1'b0;
            end
         end
         DATA: begin
            if (read_q && match_q) begin
               if (fall_q) begin
                  if (cnt_q != 6'd16) begin
                     mdio_o_d = sh_q[4'd15 - cnt_q[3:0]];
                     cnt_d    = cnt_q + 6'd1;
                  end else begin
                     mdio_t_d   = 1'b1;
                     mdio_o_d   = 1'b1;
                     evt_rd_d   = 1'b1;
                     evt_areg_d = regad_q;
                     evt_data_d = sh_q;
                     cnt_d      = '0;
                     state_d    = IDLE;
                  end
               end
            end else if (rise_q) begin
               sh_d = commit_data;
               if (cnt_q == 6'd15) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  if (!read_q && match_q) begin
                     commit     = 1'b1;
                     evt_wr_d   = 1'b1;
                     evt_areg_d = regad_q;
                     evt_data_d = commit_data;
                  end
               end else cnt_d = cnt_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // MDIO commit is applied after the local write so it wins on an address clash.
   always_comb begin
      for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
      if (usr_wr) regs_d[usr_wr_areg] = usr_wr_data;
      if (commit) regs_d[regad_q] = commit_data;
      regs_d[2] = '0;
      regs_d[3] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mdc_sync_q  <= '1;
         mdio_sync_q <= '1;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         read_q      <= 1'b0;
         match_q     <= 1'b0;
         regad_q     <= '0;
         mdio_o_q    <= 1'b1;
         mdio_t_q    <= 1'b1;
         evt_wr_q    <= 1'b0;
         evt_rd_q    <= 1'b0;
         evt_areg_q  <= '0;
         evt_data_q  <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         mdc_sync_q  <= mdc_sync_d;
         mdio_sync_q <= mdio_sync_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         read_q      <= read_d;
         match_q     <= match_d;
         regad_q     <= regad_d;
         mdio_o_q    <= mdio_o_d;
         mdio_t_q    <= mdio_t_d;
         evt_wr_q    <= evt_wr_d;
         evt_rd_q    <= evt_rd_d;
         evt_areg_q  <= evt_areg_d;
         evt_data_q  <= evt_data_d;
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign p_out_mdio   = mdio_o_q;
   assign p_out_mdio_t = mdio_t_q;
   assign usr_evt_wr   = evt_wr_q;
   assign usr_evt_rd   = evt_rd_q;
   assign usr_evt_areg = evt_areg_q;
   assign usr_evt_data = evt_data_q;

endmodule

// File: tb/tb_eth_mdio_slave.sv
// Self-checking bench for eth_mdio_slave: directed frames plus random frames
// checked against a frame-level register model.
module tb_eth_mdio_slave;

   localparam logic [15:0] ID1 = 16'h1234;
   localparam logic [15:0] ID2 = 16'hBEEF;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        p_in_mdc = 1'b0;
   logic        p_in_mdio;
   logic        p_out_mdio, p_out_mdio_t;
   logic        usr_wr = 1'b0;
   logic [4:0]  usr_wr_areg = '0;
   logic [15:0] usr_wr_data = '0;
   logic [4:0]  usr_rd_areg = '0;
   logic [15:0] usr_rd_data;
   logic        usr_evt_wr, usr_evt_rd;
   logic [4:0]  usr_evt_areg;
   logic [15:0] usr_evt_data;
   logic        masterVal = 1'b1;

   int checkCount = 0;
   int passCount = 0;
   int wrPulses = 0;
   int rdPulses = 0;
   int driveCycles = 0;
   logic [15:0] modelRegs [32];

   eth_mdio_slave #(.G_PHYAD(5'd1), .G_PHYID1(ID1), .G_PHYID2(ID2)) dut (
      .clk(clk), .rst(rst), .p_in_mdc(p_in_mdc), .p_in_mdio(p_in_mdio),
      .p_out_mdio(p_out_mdio), .p_out_mdio_t(p_out_mdio_t),
      .usr_wr(usr_wr), .usr_wr_areg(usr_wr_areg), .usr_wr_data(usr_wr_data),
      .usr_rd_areg(usr_rd_areg), .usr_rd_data(usr_rd_data),
      .usr_evt_wr(usr_evt_wr), .usr_evt_rd(usr_evt_rd),
      .usr_evt_areg(usr_evt_areg), .usr_evt_data(usr_evt_data)
   );

   // Shared bus with pull-up: slave overrides the master when it drives.
   assign p_in_mdio = p_out_mdio_t ? masterVal : p_out_mdio;

   always #5 clk = ~clk;

   // Event pulse widths and drive activity are tallied per clock.
   always @(posedge clk) begin
      if (usr_evt_wr) wrPulses <= wrPulses + 1;
      if (usr_evt_rd) rdPulses <= rdPulses + 1;
      if (!p_out_mdio_t) driveCycles <= driveCycles + 1;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic phyMatch(input logic [4:0] a);
`ifdef ETH_MDIO_SLAVE_BCAST_EN
      return (a == 5'd1) || (a == 5'd0);
`else
      return a == 5'd1;
`endif
   endfunction

   function automatic logic writable(input logic [4:0] a);
      return (a != 5'd2) && (a != 5'd3);
   endfunction

   function automatic logic [15:0] modelRead(input logic [4:0] a);
      if (a == 5'd2) return ID1;
      if (a == 5'd3) return ID2;
      return modelRegs[a];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h required %0h", tag, obs, exp);
   endtask

   // One MDC period: fall, hold low H clk, rise, hold high H clk; optional local
   // write strobe timed to land on the same clk as the slave's commit.
   task automatic mdioBit(input logic b, input logic coll, output logic pinS, output logic tS);
      p_in_mdc = 1'b0;
      masterVal = b;
      repeat (H) @(posedge clk);
      #1;
      pinS = p_in_mdio;
      tS = p_out_mdio_t;
      p_in_mdc = 1'b1;
      if (coll) begin
         repeat (3) @(posedge clk);
         #1 usr_wr = 1'b1;
         @(posedge clk);
         #1 usr_wr = 1'b0;
         repeat (H - 4) @(posedge clk);
         #1;
      end else begin
         repeat (H) @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int preLen, input logic isRead, input logic [4:0] phy,
                                input logic [4:0] regA, input logic [15:0] wdata, input logic coll,
                                input int abortAt, output logic [15:0] rdata, output logic ta1T,
                                output logic ta2Pin, output logic ta2T);
      logic p, t;
      rdata = '0;
      mdioBit(1'b0, 1'b0, p, t);
      for (int i = 0; i < preLen; i++) mdioBit(1'b1, 1'b0, p, t);
      mdioBit(1'b0, 1'b0, p, t);
      mdioBit(1'b1, 1'b0, p, t);
      mdioBit(isRead, 1'b0, p, t);
      mdioBit(!isRead, 1'b0, p, t);
      for (int i = 4; i >= 0; i--) mdioBit(phy[i], 1'b0, p, t);
      for (int i = 4; i >= 0; i--) mdioBit(regA[i], 1'b0, p, t);
      mdioBit(1'b1, 1'b0, p, ta1T);
      mdioBit(isRead, 1'b0, ta2Pin, ta2T);
      for (int i = 15; i >= 0; i--) begin
         if (isRead && i == abortAt) begin
            p_in_mdc = 1'b0;
            masterVal = 1'b1;
            repeat (4) @(posedge clk);
            #2;
            checkOutput("abortDriving", 32'(p_out_mdio_t), 32'd0);
            rst = 1'b0;
            #1;
            checkOutput("abortRelease", 32'(p_out_mdio_t), 32'd1);
            checkOutput("abortMdio", 32'(p_out_mdio), 32'd1);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            for (int k = 0; k < 32; k++) modelRegs[k] = '0;
            return;
         end
         if (isRead) begin
            mdioBit(1'b1, 1'b0, p, t);
            rdata[i] = p;
         end else mdioBit(wdata[i], coll && (i == 0), p, t);
      end
      mdioBit(1'b1, 1'b0, p, t);
      p_in_mdc = 1'b0;
      masterVal = 1'b1;
      repeat (2 * H) @(posedge clk);
      #1;
   endtask

   // Runs one frame and checks every observable against the model.
   task automatic doFrame(input string tag, input int preLen, input logic isRead,
                          input logic [4:0] phy, input logic [4:0] regA,
                          input logic [15:0] wdata, input logic coll);
      int w0, r0, d0;
      logic ans, ta1T, ta2Pin, ta2T;
      logic [15:0] rdata, expRd;
      w0 = wrPulses;
      r0 = rdPulses;
      d0 = driveCycles;
      ans = (preLen >= 32) && phyMatch(phy);
      expRd = modelRead(regA);
      applyStimulus(preLen, isRead, phy, regA, wdata, coll, -1, rdata, ta1T, ta2Pin, ta2T);
      if (coll && writable(usr_wr_areg)) modelRegs[usr_wr_areg] = usr_wr_data;
      if (!isRead) begin
         if (ans && writable(regA)) modelRegs[regA] = wdata;
         if (!(ans && !writable(regA)))
            checkOutput({tag, ".wrPulse"}, 32'(wrPulses - w0), 32'(ans));
         if (ans && writable(regA)) begin
            checkOutput({tag, ".evtAreg"}, 32'(usr_evt_areg), 32'(regA));
            checkOutput({tag, ".evtData"}, 32'(usr_evt_data), 32'(wdata));
         end
         checkOutput({tag, ".rdPulse"}, 32'(rdPulses - r0), 32'd0);
      end else begin
         checkOutput({tag, ".rdPulse"}, 32'(rdPulses - r0), 32'(ans));
         checkOutput({tag, ".wrPulse"}, 32'(wrPulses - w0), 32'd0);
         if (ans) begin
            checkOutput({tag, ".rdData"}, 32'(rdata), 32'(expRd));
            checkOutput({tag, ".ta1Rel"}, 32'(ta1T), 32'd1);
            checkOutput({tag, ".ta2Drv"}, 32'(ta2T), 32'd0);
            checkOutput({tag, ".ta2Zero"}, 32'(ta2Pin), 32'd0);
            checkOutput({tag, ".evtAreg"}, 32'(usr_evt_areg), 32'(regA));
            checkOutput({tag, ".evtData"}, 32'(usr_evt_data), 32'(expRd));
         end
      end
      checkOutput({tag, ".drove"}, 32'(driveCycles != d0), 32'(isRead && ans));
      checkOutput({tag, ".released"}, 32'(p_out_mdio_t), 32'd1);
      usr_rd_areg = regA;
      #1;
      checkOutput({tag, ".regFile"}, 32'(usr_rd_data), 32'(modelRead(regA)));
   endtask

   task automatic localWrite(input logic [4:0] a, input logic [15:0] d);
      usr_wr_areg = a;
      usr_wr_data = d;
      usr_wr = 1'b1;
      @(posedge clk);
      #1 usr_wr = 1'b0;
      if (writable(a)) modelRegs[a] = d;
      usr_rd_areg = a;
      #1;
      checkOutput("localWrite", 32'(usr_rd_data), 32'(modelRead(a)));
   endtask

   initial begin
      logic [15:0] rdata;
      logic ta1T, ta2Pin, ta2T;
      int r0;
      logic [4:0] phy, regA;
      for (int k = 0; k < 32; k++) modelRegs[k] = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstMdioT", 32'(p_out_mdio_t), 32'd1);
      checkOutput("rstMdio", 32'(p_out_mdio), 32'd1);
      checkOutput("rstEvtWr", 32'(usr_evt_wr), 32'd0);
      checkOutput("rstEvtRd", 32'(usr_evt_rd), 32'd0);
      checkOutput("rstEvtAreg", 32'(usr_evt_areg), 32'd0);
      checkOutput("rstEvtData", 32'(usr_evt_data), 32'd0);
      usr_rd_areg = 5'd4;
      #1 checkOutput("rstReg4", 32'(usr_rd_data), 32'd0);
      usr_rd_areg = 5'd2;
      #1 checkOutput("rstReg2", 32'(usr_rd_data), 32'(ID1));
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      doFrame("write4", 32, 1'b0, 5'd1, 5'd4, 16'hA5C3, 1'b0);
      doFrame("read4", 32, 1'b1, 5'd1, 5'd4, 16'h0000, 1'b0);
      doFrame("shortPre", 31, 1'b1, 5'd1, 5'd4, 16'h0000, 1'b0);
      doFrame("phy7", 32, 1'b1, 5'd7, 5'd4, 16'h0000, 1'b0);
      doFrame("roReg2", 32, 1'b0, 5'd1, 5'd2, 16'hFFFF, 1'b0);
      doFrame("readId2", 32, 1'b1, 5'd1, 5'd3, 16'h0000, 1'b0);

      usr_wr_areg = 5'd4;
      usr_wr_data = 16'h1111;
      doFrame("collSame", 32, 1'b0, 5'd1, 5'd4, 16'h2222, 1'b1);
      usr_wr_areg = 5'd5;
      doFrame("collDiff", 32, 1'b0, 5'd1, 5'd6, 16'h3333, 1'b1);
      usr_rd_areg = 5'd5;
      #1 checkOutput("collDiffLocal", 32'(usr_rd_data), 32'h1111);

      r0 = rdPulses;
      applyStimulus(32, 1'b1, 5'd1, 5'd6, 16'h0000, 1'b0, 8, rdata, ta1T, ta2Pin, ta2T);
      repeat (4 * H) @(posedge clk);
      #1;
      checkOutput("abortNoEvt", 32'(rdPulses - r0), 32'd0);
      checkOutput("abortEvtData", 32'(usr_evt_data), 32'd0);
      doFrame("postRstWr", 32, 1'b0, 5'd1, 5'd9, 16'h5A3C, 1'b0);
      doFrame("postRstRd", 32, 1'b1, 5'd1, 5'd9, 16'h0000, 1'b0);
      doFrame("bcastRd", 32, 1'b1, 5'd0, 5'd9, 16'h0000, 1'b0);
      doFrame("bcastWr", 32, 1'b0, 5'd0, 5'd10, 16'hC0DE, 1'b0);

      for (int n = 0; n < 14; n++) begin
         case ($urandom_range(0, 4))
            0, 1: phy = 5'd1;
            2: phy = 5'd0;
            3: phy = 5'd7;
            default: phy = 5'($urandom_range(0, 31));
         endcase
         regA = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) localWrite(5'($urandom_range(0, 31)), 16'($urandom));
         doFrame($sformatf("rnd%0d", n), 32, 1'($urandom_range(0, 1)), phy, regA, 16'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
